// File: rtl/axis_frame_source_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axis_frame_source_pkg
// Purpose  : Shared types and constants for the framed AXI-Stream source:
//            state encoding, the constant TSTRB value and the smallest legal
//            frame length.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package axis_frame_source_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    GAP   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam logic [3:0] TSTRB_ALL     = 4'hF;
  localparam int         MIN_FRAME_LEN = 2;

endpackage
`default_nettype wire

// File: rtl/axis_out_reg.sv
`default_nettype none
// ============================================================================
// Module   : axis_out_reg
// Purpose  : Single-entry AXI-Stream output register. A new beat is accepted
//            when the register is free (empty, or emptying this cycle through
//            a handshake). An offered beat that cannot be accepted is reported
//            on drop and is not stored.
// Ports    : clk, rst      - clock, asynchronous active-high reset
//            en            - offers are considered only while en is high
//            in_valid/in_data/in_last - offered beat
//            tready        - downstream ready
//            tvalid/tdata/tlast - registered stream outputs
//            load / drop   - offered beat accepted / rejected this cycle
// Revision : 1.0 - initial release
// ============================================================================
module axis_out_reg #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  input  logic              tready,
  output logic              tvalid,
  output logic [DATA_W-1:0] tdata,
  output logic              tlast,
  output logic              load,
  output logic              drop
);

  logic              tvalid_q, tvalid_d;
  logic [DATA_W-1:0] tdata_q, tdata_d;
  logic              tlast_q, tlast_d;
  logic              free;

  // Free when empty, or when the held beat is taken on this same edge.
  assign free = !tvalid_q || tready;
  assign load = en && in_valid && free;
  assign drop = en && in_valid && !free;

  always_comb begin
    tvalid_d = tvalid_q;
    tdata_d  = tdata_q;
    tlast_d  = tlast_q;
    if (load) begin
      tvalid_d = 1'b1;
      tdata_d  = in_data;
      tlast_d  = in_last;
    end else if (tvalid_q && tready) begin
      tvalid_d = 1'b0;
      tlast_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
      tlast_q  <= 1'b0;
    end else begin
      tvalid_q <= tvalid_d;
      tdata_q  <= tdata_d;
      tlast_q  <= tlast_d;
    end
  end

  assign tvalid = tvalid_q;
  assign tdata  = tdata_q;
  assign tlast  = tlast_q;

endmodule
`default_nettype wire

// File: rtl/axis_frame_source.sv
`default_nettype none
// ============================================================================
// Module   : axis_frame_source
// Purpose  : Frames a free-running ADC sample stream into fixed-length
//            AXI-Stream frames (TLAST on the final beat) with a programmable
//            number of discarded samples between frames. Samples arriving
//            while the output register is held are dropped and counted.
// Ports    : clk, rst                 - clock, asynchronous active-high reset
//            adc_valid, adc_data      - sample stream, lane i at [i*16 +: 16]
//            cfg_frame_len/gap/num_frames - run configuration, latched at start
//            start, stop              - run control pulses
//            overflow_clr             - clears overflow and drop_cnt
//            M_AXIS_*                 - framed AXI-Stream master
//            busy, cfg_err, frames_done, overflow, drop_cnt - status
// Revision : 1.0 - initial release
// ============================================================================
module axis_frame_source
  import axis_frame_source_pkg::*;
#(
  parameter int CHANNELS = 2,
  parameter int LEN_W    = 12,
  parameter int CNT_W    = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   adc_valid,
  input  logic [CHANNELS*16-1:0] adc_data,
  input  logic [LEN_W-1:0]       cfg_frame_len,
  input  logic [LEN_W-1:0]       cfg_gap,
  input  logic [CNT_W-1:0]       cfg_num_frames,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   overflow_clr,
  output logic                   M_AXIS_TVALID,
  output logic [CHANNELS*16-1:0] M_AXIS_TDATA,
  output logic [3:0]             M_AXIS_TSTRB,
  output logic                   M_AXIS_TLAST,
  input  logic                   M_AXIS_TREADY,
  output logic                   busy,
  output logic                   cfg_err,
  output logic [CNT_W-1:0]       frames_done,
  output logic                   overflow,
  output logic [CNT_W-1:0]       drop_cnt
);

  localparam int DATA_W = CHANNELS * 16;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] gap_q, gap_d;
  logic [LEN_W-1:0] sample_cnt_q, sample_cnt_d;
  logic [LEN_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [CNT_W-1:0] num_frames_q, num_frames_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0] frames_done_q, frames_done_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic             stop_pending_q, stop_pending_d;
  logic             overflow_q, overflow_d;
  logic             cfg_err_q, cfg_err_d;

  logic out_en, out_load, out_drop;
  logic is_last, stop_seen, last_frame, last_hs;

  assign out_en     = (state_q == RUN);
  assign is_last    = (sample_cnt_q == len_q - LEN_W'(1));
  assign stop_seen  = stop_pending_q || stop;
  // frame_cnt counts frames whose last sample has been loaded, so the frame
  // being closed now is number frame_cnt+1.
  assign last_frame = (num_frames_q != '0) && (frame_cnt_q + CNT_W'(1) == num_frames_q);
  assign last_hs    = M_AXIS_TVALID && M_AXIS_TREADY && M_AXIS_TLAST;

  axis_out_reg #(
    .DATA_W (DATA_W)
  ) u_out_reg (
    .clk      (clk),
    .rst      (rst),
    .en       (out_en),
    .in_valid (adc_valid),
    .in_data  (adc_data),
    .in_last  (is_last),
    .tready   (M_AXIS_TREADY),
    .tvalid   (M_AXIS_TVALID),
    .tdata    (M_AXIS_TDATA),
    .tlast    (M_AXIS_TLAST),
    .load     (out_load),
    .drop     (out_drop)
  );

  always_comb begin
    state_d        = state_q;
    len_d          = len_q;
    gap_d          = gap_q;
    sample_cnt_d   = sample_cnt_q;
    gap_cnt_d      = gap_cnt_q;
    num_frames_d   = num_frames_q;
    frame_cnt_d    = frame_cnt_q;
    frames_done_d  = frames_done_q;
    drop_cnt_d     = drop_cnt_q;
    stop_pending_d = stop_pending_q;
    overflow_d     = overflow_q;
    cfg_err_d      = 1'b0;

    if (last_hs) begin
      frames_done_d = frames_done_q + CNT_W'(1);
    end

    // A drop in the same cycle as a clear restarts the count at one.
    if (overflow_clr) begin
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end
    if (out_drop) begin
      overflow_d = 1'b1;
      if (overflow_clr) begin
        drop_cnt_d = CNT_W'(1);
      end else if (drop_cnt_q != {CNT_W{1'b1}}) begin
        drop_cnt_d = drop_cnt_q + CNT_W'(1);
      end
    end

    case (state_q)
      IDLE: begin
        stop_pending_d = 1'b0;
        if (start) begin
          if (cfg_frame_len >= LEN_W'(MIN_FRAME_LEN)) begin
            len_d         = cfg_frame_len;
            gap_d         = cfg_gap;
            num_frames_d  = cfg_num_frames;
            frames_done_d = '0;
            frame_cnt_d   = '0;
            sample_cnt_d  = '0;
            gap_cnt_d     = '0;
            state_d       = RUN;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end

      RUN: begin
        if (stop) begin
          stop_pending_d = 1'b1;
        end
        if (out_load) begin
          if (is_last) begin
            sample_cnt_d = '0;
            gap_cnt_d    = '0;
            frame_cnt_d  = frame_cnt_q + CNT_W'(1);
            if (last_frame || stop_seen) begin
              state_d = DRAIN;
            end else if (gap_q != '0) begin
              state_d = GAP;
            end
          end else begin
            sample_cnt_d = sample_cnt_q + LEN_W'(1);
          end
        end
      end

      GAP: begin
        if (stop) begin
          stop_pending_d = 1'b1;
        end
        // Once stopping, gap samples no longer matter; just let the last
        // frame's final beat leave the register.
        if (stop_seen) begin
          if (!M_AXIS_TVALID) begin
            state_d = IDLE;
          end
        end else if (adc_valid) begin
          if (gap_cnt_q == gap_q - LEN_W'(1)) begin
            gap_cnt_d = '0;
            state_d   = RUN;
          end else begin
            gap_cnt_d = gap_cnt_q + LEN_W'(1);
          end
        end
      end

      DRAIN: begin
        if (last_hs) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      len_q          <= '0;
      gap_q          <= '0;
      sample_cnt_q   <= '0;
      gap_cnt_q      <= '0;
      num_frames_q   <= '0;
      frame_cnt_q    <= '0;
      frames_done_q  <= '0;
      drop_cnt_q     <= '0;
      stop_pending_q <= 1'b0;
      overflow_q     <= 1'b0;
      cfg_err_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      len_q          <= len_d;
      gap_q          <= gap_d;
      sample_cnt_q   <= sample_cnt_d;
      gap_cnt_q      <= gap_cnt_d;
      num_frames_q   <= num_frames_d;
      frame_cnt_q    <= frame_cnt_d;
      frames_done_q  <= frames_done_d;
      drop_cnt_q     <= drop_cnt_d;
      stop_pending_q <= stop_pending_d;
      overflow_q     <= overflow_d;
      cfg_err_q      <= cfg_err_d;
    end
  end

  assign M_AXIS_TSTRB = TSTRB_ALL;
  assign busy         = (state_q != IDLE);
  assign cfg_err      = cfg_err_q;
  assign frames_done  = frames_done_q;
  assign overflow     = overflow_q;
  assign drop_cnt     = drop_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_axis_frame_source.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_axis_frame_source
// Purpose  : Self-checking bench for axis_frame_source. ADC data is a ramp
//            that advances on every offered sample, so delivered beat values
//            reveal exactly which samples were framed, skipped or dropped.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axis_frame_source;

  localparam int CHANNELS = 2;
  localparam int LEN_W    = 12;
  localparam int CNT_W    = 16;
  localparam int DW       = CHANNELS * 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             adc_valid;
  logic [DW-1:0]    adc_data;
  logic [LEN_W-1:0] cfg_frame_len;
  logic [LEN_W-1:0] cfg_gap;
  logic [CNT_W-1:0] cfg_num_frames;
  logic             start;
  logic             stop;
  logic             overflow_clr;
  logic             M_AXIS_TVALID;
  logic [DW-1:0]    M_AXIS_TDATA;
  logic [3:0]       M_AXIS_TSTRB;
  logic             M_AXIS_TLAST;
  logic             M_AXIS_TREADY;
  logic             busy;
  logic             cfg_err;
  logic [CNT_W-1:0] frames_done;
  logic             overflow;
  logic [CNT_W-1:0] drop_cnt;

  axis_frame_source #(
    .CHANNELS (CHANNELS),
    .LEN_W    (LEN_W),
    .CNT_W    (CNT_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .adc_valid      (adc_valid),
    .adc_data       (adc_data),
    .cfg_frame_len  (cfg_frame_len),
    .cfg_gap        (cfg_gap),
    .cfg_num_frames (cfg_num_frames),
    .start          (start),
    .stop           (stop),
    .overflow_clr   (overflow_clr),
    .M_AXIS_TVALID  (M_AXIS_TVALID),
    .M_AXIS_TDATA   (M_AXIS_TDATA),
    .M_AXIS_TSTRB   (M_AXIS_TSTRB),
    .M_AXIS_TLAST   (M_AXIS_TLAST),
    .M_AXIS_TREADY  (M_AXIS_TREADY),
    .busy           (busy),
    .cfg_err        (cfg_err),
    .frames_done    (frames_done),
    .overflow       (overflow),
    .drop_cnt       (drop_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] beats_q[$];
  logic          lasts_q[$];
  logic          prev_held = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic          prev_last = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Beat monitor on the falling edge: records every beat that will handshake
  // on the next rising edge and checks that a stalled beat is held unchanged.
  always @(negedge clk) begin
    if (!rst) begin
      if (prev_held) begin
        chk("hold_tvalid", {63'd0, M_AXIS_TVALID}, 64'd1);
        chk("hold_tdata", {32'd0, M_AXIS_TDATA}, {32'd0, prev_data});
        chk("hold_tlast", {63'd0, M_AXIS_TLAST}, {63'd0, prev_last});
      end
      if (M_AXIS_TVALID && M_AXIS_TREADY) begin
        beats_q.push_back(M_AXIS_TDATA);
        lasts_q.push_back(M_AXIS_TLAST);
      end
    end
    prev_held <= !rst && M_AXIS_TVALID && !M_AXIS_TREADY;
    prev_data <= M_AXIS_TDATA;
    prev_last <= M_AXIS_TLAST;
  end

  // Advance one clock; the ramp moves on whenever a sample was offered.
  task automatic tick();
    @(posedge clk);
    #1;
    if (adc_valid) adc_data = adc_data + 1'b1;
  endtask

  task automatic run(input int len, input int gap, input int nf, input int vpct,
                     input int rpct, input int stop_at, input bit exp_err);
    int cyc;
    bit stopped;
    beats_q.delete();
    lasts_q.delete();
    cfg_frame_len  = LEN_W'(len);
    cfg_gap        = LEN_W'(gap);
    cfg_num_frames = CNT_W'(nf);
    adc_data       = '0;
    adc_valid      = 1'b0;
    M_AXIS_TREADY  = 1'b1;
    stop           = 1'b0;
    start          = 1'b1;
    tick();
    start = 1'b0;
    chk("cfg_err", {63'd0, cfg_err}, {63'd0, exp_err});
    chk("busy_after_start", {63'd0, busy}, {63'd0, !exp_err});
    chk("tvalid_before_sample", {63'd0, M_AXIS_TVALID}, 64'd0);
    cyc     = 0;
    stopped = 1'b0;
    while (busy && cyc < 20000) begin
      adc_valid     = ($urandom_range(99) < vpct);
      M_AXIS_TREADY = ($urandom_range(99) < rpct);
      if (stop_at != 0 && !stopped && beats_q.size() >= stop_at) begin
        stop    = 1'b1;
        stopped = 1'b1;
      end else begin
        stop = 1'b0;
      end
      tick();
      cyc++;
      if (cyc == 1 && vpct == 100) begin
        chk("first_tvalid_latency", {63'd0, M_AXIS_TVALID}, 64'd1);
        chk("first_tdata", {32'd0, M_AXIS_TDATA}, 64'd0);
      end
    end
    chk("run_completes", {63'd0, busy}, 64'd0);
    adc_valid     = 1'b0;
    stop          = 1'b0;
    M_AXIS_TREADY = 1'b1;
    tick();
  endtask

  // Continuous-valid framing model: beat k of a run is sample
  // frame*(len+gap)+index, and only index len-1 carries TLAST.
  task automatic check_frames(input int len, input int gap, input int exp_beats);
    int n;
    chk("beat_count", 64'(beats_q.size()), 64'(exp_beats));
    n = (beats_q.size() < exp_beats) ? beats_q.size() : exp_beats;
    for (int k = 0; k < n; k++) begin
      chk("beat_data", {32'd0, beats_q[k]}, 64'((k / len) * (len + gap) + (k % len)));
      chk("beat_last", {63'd0, lasts_q[k]}, {63'd0, ((k % len) == len - 1)});
    end
  endtask

  typedef struct {
    int len;
    int gap;
    int nf;
    bit exp_err;
    int exp_beats;
    int exp_last_data;
    int exp_frames;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int n;
    int total_drops;
    int bad;
    int jump;
    int exp_bp[6];
    bit exp_bp_last[6];

    // len, gap, frames, cfg_err, beats, last beat data, frames_done
    vecs[0] = '{1, 0, 1, 1'b1, 0, 0, 0};
    vecs[1] = '{0, 0, 1, 1'b1, 0, 0, 0};
    vecs[2] = '{2, 0, 3, 1'b0, 6, 5, 3};
    vecs[3] = '{8, 0, 2, 1'b0, 16, 15, 2};
    vecs[4] = '{4, 3, 3, 1'b0, 12, 17, 3};
    vecs[5] = '{5, 1, 2, 1'b0, 10, 10, 2};
    exp_bp      = '{0, 1, 4, 5, 6, 7};
    exp_bp_last = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    rst            = 1'b1;
    adc_valid      = 1'b0;
    adc_data       = '0;
    cfg_frame_len  = '0;
    cfg_gap        = '0;
    cfg_num_frames = '0;
    start          = 1'b0;
    stop           = 1'b0;
    overflow_clr   = 1'b0;
    M_AXIS_TREADY  = 1'b1;
    tick();
    tick();
    chk("rst_tvalid", {63'd0, M_AXIS_TVALID}, 64'd0);
    chk("rst_tdata", {32'd0, M_AXIS_TDATA}, 64'd0);
    chk("rst_tlast", {63'd0, M_AXIS_TLAST}, 64'd0);
    chk("rst_tstrb", {60'd0, M_AXIS_TSTRB}, 64'hF);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_overflow", {63'd0, overflow}, 64'd0);
    chk("rst_drop_cnt", {48'd0, drop_cnt}, 64'd0);
    chk("rst_frames_done", {48'd0, frames_done}, 64'd0);
    rst = 1'b0;
    tick();

    // Table: continuous valid, TREADY always high.
    for (int v = 0; v < 6; v++) begin
      run(vecs[v].len, vecs[v].gap, vecs[v].nf, 100, 100, 0, vecs[v].exp_err);
      check_frames((vecs[v].len < 2) ? 2 : vecs[v].len, vecs[v].gap, vecs[v].exp_beats);
      if (vecs[v].exp_beats > 0 && beats_q.size() == vecs[v].exp_beats)
        chk("last_beat_data", {32'd0, beats_q[vecs[v].exp_beats-1]}, 64'(vecs[v].exp_last_data));
      chk("frames_done", {48'd0, frames_done}, 64'(vecs[v].exp_frames));
      chk("no_overflow", {63'd0, overflow}, 64'd0);
      chk("cfg_err_one_cycle", {63'd0, cfg_err}, 64'd0);
    end

    // Continuous run stopped in the middle of frame 3: frame 3 completes.
    run(4, 3, 0, 100, 100, 9, 1'b0);
    check_frames(4, 3, 12);
    chk("stop_frames_done", {48'd0, frames_done}, 64'd3);

    // Backpressure on beat 2 for two clocks: samples 2 and 3 are dropped.
    beats_q.delete();
    lasts_q.delete();
    cfg_frame_len  = LEN_W'(6);
    cfg_gap        = '0;
    cfg_num_frames = CNT_W'(1);
    adc_data       = '0;
    start          = 1'b1;
    tick();
    start     = 1'b0;
    adc_valid = 1'b1;
    tick();
    tick();
    M_AXIS_TREADY = 1'b0;
    tick();
    chk("bp_held_tdata", {32'd0, M_AXIS_TDATA}, 64'd1);
    chk("bp_drop_cnt_1", {48'd0, drop_cnt}, 64'd1);
    tick();
    chk("bp_drop_cnt_2", {48'd0, drop_cnt}, 64'd2);
    chk("bp_overflow", {63'd0, overflow}, 64'd1);
    M_AXIS_TREADY = 1'b1;
    n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    chk("bp_completes", {63'd0, busy}, 64'd0);
    adc_valid = 1'b0;
    chk("bp_beats", 64'(beats_q.size()), 64'd6);
    for (int k = 0; k < 6 && k < beats_q.size(); k++) begin
      chk("bp_data", {32'd0, beats_q[k]}, 64'(exp_bp[k]));
      chk("bp_last", {63'd0, lasts_q[k]}, {63'd0, exp_bp_last[k]});
    end
    chk("bp_drop_final", {48'd0, drop_cnt}, 64'd2);
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
    chk("clr_overflow", {63'd0, overflow}, 64'd0);
    chk("clr_drop_cnt", {48'd0, drop_cnt}, 64'd0);

    // Asynchronous reset while the fourth beat is presented.
    beats_q.delete();
    lasts_q.delete();
    cfg_frame_len  = LEN_W'(8);
    cfg_num_frames = '0;
    adc_data       = '0;
    start          = 1'b1;
    tick();
    start     = 1'b0;
    adc_valid = 1'b1;
    n = 0;
    while (beats_q.size() < 3 && n < 100) begin
      tick();
      n++;
    end
    chk("pre_rst_beats", 64'(beats_q.size()), 64'd3);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_tvalid", {63'd0, M_AXIS_TVALID}, 64'd0);
    chk("arst_tdata", {32'd0, M_AXIS_TDATA}, 64'd0);
    chk("arst_tlast", {63'd0, M_AXIS_TLAST}, 64'd0);
    chk("arst_busy", {63'd0, busy}, 64'd0);
    chk("arst_tstrb", {60'd0, M_AXIS_TSTRB}, 64'hF);
    adc_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    run(8, 0, 1, 100, 100, 0, 1'b0);
    check_frames(8, 0, 8);
    chk("post_rst_frames_done", {48'd0, frames_done}, 64'd1);

    // Random valid and ready: frames stay exact length, every offered sample
    // in RUN is either delivered or counted as dropped.
    run(32, 2, 40, 70, 50, 0, 1'b0);
    chk("rand_beats", 64'(beats_q.size()), 64'd1280);
    chk("rand_frames_done", {48'd0, frames_done}, 64'd40);
    total_drops = 0;
    bad         = 0;
    for (int k = 0; k < beats_q.size(); k++) begin
      if (lasts_q[k] !== ((k % 32) == 31)) bad++;
      if (k > 0) begin
        jump = int'(beats_q[k]) - int'(beats_q[k-1]) - 1;
        if ((k % 32) == 0) jump = jump - 2;
        if (jump < 0) bad++;
        else total_drops += jump;
      end
    end
    if (beats_q.size() > 0) chk("rand_first_beat", {32'd0, beats_q[0]}, 64'd0);
    chk("rand_framing_errors", 64'(bad), 64'd0);
    chk("rand_drop_cnt", {48'd0, drop_cnt}, 64'(total_drops));
    chk("rand_overflow", {63'd0, overflow}, {63'd0, (total_drops != 0)});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
